// File: rtl/trackball_quad_gen.sv
// Converts joystick levels and mouse deltas into rate-limited Gray-code quadrature
// phase pairs (A leads B on forward motion) for the Crystal Castles trackball input.
module trackball_quad_gen #(
    parameter int STEP_DIV = 2500,
    parameter int JOY_DIV  = 20000,
    parameter int ACC_W    = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              joy_left,
    input  logic              joy_right,
    input  logic              joy_up,
    input  logic              joy_down,
    input  logic              mouse_stb,
    input  logic signed [8:0] mouse_dx,
    input  logic signed [8:0] mouse_dy,
    input  logic [1:0]        mouse_scale,
    output logic [1:0]        quad_x,
    output logic [1:0]        quad_y,
    output logic              busy
);
    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int JOY_W  = $clog2(JOY_DIV);
    // A fully scaled mouse delta needs 12 bits, so the sum never drops below 14.
    localparam int SUM_W  = (ACC_W + 4 > 14) ? ACC_W + 4 : 14;

    localparam logic [STEP_W-1:0]       STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [JOY_W-1:0]        JOY_LAST  = JOY_W'(JOY_DIV - 1);
    localparam logic signed [SUM_W-1:0] S_ZERO    = '0;
    localparam logic signed [SUM_W-1:0] S_ONE     = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SUM_LIM   = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_LIM   = ACC_W'((1 << (ACC_W - 1)) - 1);

    function automatic logic signed [SUM_W-1:0] scale_delta(input logic signed [8:0] d,
                                                           input logic [1:0] sh);
        logic signed [SUM_W-1:0] ext;
        ext = {{(SUM_W - 9){d[8]}}, d};
        return ext <<< sh;
    endfunction

    function automatic logic signed [SUM_W-1:0] widen_acc(input logic signed [ACC_W-1:0] a);
        return {{(SUM_W - ACC_W){a[ACC_W-1]}}, a};
    endfunction

    // Symmetric clamp: the most-negative code is never produced.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > SUM_LIM)
            r = ACC_LIM;
        else if (v < -SUM_LIM)
            r = -ACC_LIM;
        else
            r = $signed(v[ACC_W-1:0]);
        return r;
    endfunction

    function automatic logic [1:0] phase_fwd(input logic [1:0] p);
        logic [1:0] r;
        case (p)
            2'b00:   r = 2'b10;
            2'b10:   r = 2'b11;
            2'b11:   r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] phase_bwd(input logic [1:0] p);
        logic [1:0] r;
        case (p)
            2'b00:   r = 2'b01;
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              step_tick;

    always_comb begin
        step_tick  = (step_cnt_q == STEP_LAST);
        step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            step_cnt_q <= '0;
        else
            step_cnt_q <= step_cnt_d;
    end

    // Axis 0 is X (right/left, dx), axis 1 is Y (down/up, dy).
    logic [1:0]        dir_pos, dir_neg, axis_busy;
    logic signed [8:0] delta [2];
    logic [1:0][1:0]   phase_out;

    assign dir_pos  = {joy_down, joy_right};
    assign dir_neg  = {joy_up, joy_left};
    assign delta[0] = mouse_dx;
    assign delta[1] = mouse_dy;

    for (genvar a = 0; a < 2; a++) begin : g_axis
        logic [JOY_W-1:0]        joy_tmr_q, joy_tmr_d;
        logic signed [ACC_W-1:0] acc_q, acc_d;
        logic [1:0]              phase_q, phase_d;
        logic                    joy_one, joy_wrap, acc_pos, acc_neg;
        logic signed [SUM_W-1:0] mouse_term, joy_term, step_term, acc_sum;

        always_comb begin
            joy_one  = dir_pos[a] ^ dir_neg[a];
            joy_wrap = joy_one && (joy_tmr_q == JOY_LAST);
            if (!joy_one || joy_wrap)
                joy_tmr_d = '0;
            else
                joy_tmr_d = joy_tmr_q + JOY_W'(1);

            acc_pos = (acc_q != '0) && !acc_q[ACC_W-1];
            acc_neg = acc_q[ACC_W-1];

            mouse_term = mouse_stb ? scale_delta(delta[a], mouse_scale) : S_ZERO;
            joy_term   = !joy_wrap ? S_ZERO : (dir_pos[a] ? S_ONE : -S_ONE);

            // A step consumes one unit of pending motion in the direction it moves.
            step_term = S_ZERO;
            phase_d   = phase_q;
            if (step_tick && acc_pos) begin
                step_term = -S_ONE;
                phase_d   = phase_fwd(phase_q);
            end else if (step_tick && acc_neg) begin
                step_term = S_ONE;
                phase_d   = phase_bwd(phase_q);
            end

            acc_sum = widen_acc(acc_q) + mouse_term + joy_term + step_term;
            acc_d   = sat_acc(acc_sum);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                joy_tmr_q <= '0;
                acc_q     <= '0;
                phase_q   <= 2'b00;
            end else begin
                joy_tmr_q <= joy_tmr_d;
                acc_q     <= acc_d;
                phase_q   <= phase_d;
            end
        end

        assign phase_out[a] = phase_q;
        assign axis_busy[a] = (acc_q != '0);
    end

    assign quad_x = phase_out[0];
    assign quad_y = phase_out[1];
    assign busy   = |axis_busy;

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Scoreboard bench for trackball_quad_gen: stimulus queues the expected quadrature
// edges, a monitor pops and compares each observed edge (phase and spacing).
module tb_trackball_quad_gen;
    localparam int STEP_DIV = 4;
    localparam int JOY_DIV  = 16;
    localparam int ACC_W    = 6;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              joy_left = 1'b0, joy_right = 1'b0, joy_up = 1'b0, joy_down = 1'b0;
    logic              mouse_stb = 1'b0;
    logic signed [8:0] mouse_dx = '0, mouse_dy = '0;
    logic [1:0]        mouse_scale = '0;
    logic [1:0]        quad_x, quad_y;
    logic              busy;

    trackball_quad_gen #(.STEP_DIV(STEP_DIV), .JOY_DIV(JOY_DIV), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .joy_left(joy_left), .joy_right(joy_right), .joy_up(joy_up), .joy_down(joy_down),
        .mouse_stb(mouse_stb), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
        .mouse_scale(mouse_scale), .quad_x(quad_x), .quad_y(quad_y), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ph;
        int         gap;
    } exp_t;

    exp_t       qx[$], qy[$];
    int         total = 0, bad = 0, cyc = 0, stc = 0;
    logic [1:0] px = 2'b00, py = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) stc <= 0;
        else          stc <= (stc == STEP_DIV - 1) ? 0 : stc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [1:0] step_ph(input logic [1:0] p, input bit fwd);
        logic [1:0] seq [4];
        int i;
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        i = 0;
        for (int k = 0; k < 4; k++) if (seq[k] == p) i = k;
        return fwd ? seq[(i + 1) % 4] : seq[(i + 3) % 4];
    endfunction

    task automatic push_x(input int n, input bit fwd, input int gap);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            px = step_ph(px, fwd);
            e.ph = px;
            e.gap = (k == 0) ? 0 : gap;
            qx.push_back(e);
        end
    endtask

    task automatic push_y(input int n, input bit fwd, input int gap);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            py = step_ph(py, fwd);
            e.ph = py;
            e.gap = (k == 0) ? 0 : gap;
            qy.push_back(e);
        end
    endtask

    task automatic mouse(input int dx, input int dy, input int sc);
        @(negedge clk);
        mouse_stb = 1'b1; mouse_dx = dx[8:0]; mouse_dy = dy[8:0]; mouse_scale = sc[1:0];
        @(negedge clk);
        mouse_stb = 1'b0; mouse_dx = '0; mouse_dy = '0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((busy || qx.size() != 0 || qy.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check({name, "_pending_x"}, qx.size(), 0);
        check({name, "_pending_y"}, qy.size(), 0);
        check({name, "_idle_busy"}, busy, 0);
    endtask

    // Monitor: every change of a phase pair must match the next queued edge.
    initial begin
        logic [1:0] prev_x, prev_y;
        int last_x, last_y;
        exp_t e;
        prev_x = 2'b00; prev_y = 2'b00; last_x = 0; last_y = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_x = quad_x; prev_y = quad_y;
            end else begin
                if (quad_x !== prev_x) begin
                    if (qx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL x_unexpected_edge: actual=%b required=no edge", quad_x);
                    end else begin
                        e = qx.pop_front();
                        check("x_phase", quad_x, e.ph);
                        if (e.gap != 0) check("x_gap", cyc - last_x, e.gap);
                    end
                    last_x = cyc; prev_x = quad_x;
                end
                if (quad_y !== prev_y) begin
                    if (qy.size() == 0) begin
                        total++; bad++;
                        $display("FAIL y_unexpected_edge: actual=%b required=no edge", quad_y);
                    end else begin
                        e = qy.pop_front();
                        check("y_phase", quad_y, e.ph);
                        if (e.gap != 0) check("y_gap", cyc - last_y, e.gap);
                    end
                    last_y = cyc; prev_y = quad_y;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r;
        // Reset held with inputs toggling
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            r = $urandom;
            joy_left = r[0]; joy_right = r[1]; joy_up = r[2]; joy_down = r[3];
            mouse_stb = r[4]; mouse_dx = r[13:5]; mouse_dy = r[22:14]; mouse_scale = r[24:23];
            #1;
            check("rst_quad_x", quad_x, 0);
            check("rst_quad_y", quad_y, 0);
            check("rst_busy", busy, 0);
        end
        @(negedge clk);
        joy_left = 0; joy_right = 0; joy_up = 0; joy_down = 0;
        mouse_stb = 0; mouse_dx = '0; mouse_dy = '0; mouse_scale = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_quad_x", quad_x, 0);
        check("idle_quad_y", quad_y, 0);
        check("idle_busy", busy, 0);

        // Mouse forward: +3 -> 10, 11, 01
        push_x(3, 1'b1, STEP_DIV);
        mouse(3, 0, 0);
        check("mf_busy_next", busy, 1);
        wait_idle("mf", 40);
        check("mf_quad_x", quad_x, 2'b01);

        // Mouse reverse with scale: -2 << 1 = -4 -> 01, 11, 10, 00
        push_y(4, 1'b0, STEP_DIV);
        mouse(0, -2, 1);
        check("mr_busy_next", busy, 1);
        wait_idle("mr", 40);
        check("mr_quad_y", quad_y, 2'b00);
        check("mr_quad_x_held", quad_x, 2'b01);

        // Joystick right held 40 cycles -> two counts, 16 cycles apart
        push_x(2, 1'b1, JOY_DIV);
        @(negedge clk); joy_right = 1'b1;
        repeat (40) @(negedge clk);
        joy_right = 1'b0;
        wait_idle("joy_r", 40);
        check("joy_r_quad_x", quad_x, 2'b10);

        // Both directions held: no counts
        @(negedge clk); joy_left = 1'b1; joy_right = 1'b1;
        repeat (40) @(negedge clk);
        joy_left = 1'b0; joy_right = 1'b0;
        // Press one cycle short of a count
        @(negedge clk); joy_left = 1'b1;
        repeat (JOY_DIV - 1) @(negedge clk);
        joy_left = 1'b0;
        wait_idle("joy_none", 20);
        check("joy_none_quad_x", quad_x, 2'b10);

        // Joystick up held exactly JOY_DIV cycles -> one backward Y step
        push_y(1, 1'b0, STEP_DIV);
        @(negedge clk); joy_up = 1'b1;
        repeat (JOY_DIV) @(negedge clk);
        joy_up = 1'b0;
        wait_idle("joy_u", 20);
        check("joy_u_quad_y", quad_y, 2'b01);

        // Saturation: +255 << 3 clamps to +31, then -255 << 3 clamps to -31
        push_x(31, 1'b1, STEP_DIV);
        mouse(255, 0, 3);
        check("sat_pos_busy", busy, 1);
        wait_idle("sat_pos", 200);
        check("sat_pos_quad_x", quad_x, 2'b00);
        push_x(31, 1'b0, STEP_DIV);
        mouse(-255, 0, 3);
        check("sat_neg_busy", busy, 1);
        wait_idle("sat_neg", 200);
        check("sat_neg_quad_x", quad_x, 2'b10);

        // Mouse +1 landing on a step tick while acc_x = +1
        @(negedge clk);
        while (stc != STEP_DIV - 1) @(negedge clk);
        push_x(2, 1'b1, STEP_DIV);
        mouse_stb = 1'b1; mouse_dx = 9'sd1; mouse_scale = 2'd0;
        @(negedge clk);
        mouse_stb = 1'b0; mouse_dx = '0;
        check("sim_busy_first", busy, 1);
        while (stc != STEP_DIV - 1) @(negedge clk);
        mouse_stb = 1'b1; mouse_dx = 9'sd1;
        @(negedge clk);
        mouse_stb = 1'b0; mouse_dx = '0;
        check("sim_busy_kept", busy, 1);
        check("sim_quad_x_tick", quad_x, 2'b11);
        wait_idle("sim", 20);
        check("sim_quad_x_end", quad_x, 2'b01);

        // Reset mid-burst discards pending motion at once
        push_x(20, 1'b1, STEP_DIV);
        mouse(20, 0, 0);
        repeat (10) @(negedge clk);
        check("mid_busy_before", busy, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        qx.delete(); qy.delete();
        px = 2'b00; py = 2'b00;
        #1;
        check("mid_rst_quad_x", quad_x, 0);
        check("mid_rst_quad_y", quad_y, 0);
        check("mid_rst_busy", busy, 0);
        joy_right = 1'b1;
        repeat (3) @(negedge clk);
        joy_right = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_quad_x", quad_x, 0);
        check("post_rst_quad_y", quad_y, 0);
        check("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
